// File: rtl/usb_out_fill_sequencer.sv
// usb_out_fill_sequencer
// Routes received DATA payload bytes into the fill port of the OUT endpoint FIFO
// addressed by the preceding OUT token. It commits or rolls back each transaction
// through the FIFO's fill-done/fill-success pair and decides the handshake
// (ACK/NAK/STALL) for every OUT transaction.
//
// Optional feature macro: USB_OUT_SEQ_TOGGLE_CHECK_EN
//   Defined   : per-endpoint data toggle tracking. A good packet whose toggle does
//               not match is ACKed but rolled back, because it is a duplicate.
//   Undefined : no toggle state. rxDataToggle_i and resetDataToggle_i are unused.
//
// Ports
//   clk12_i, rst_i        12 MHz clock; asynchronous active-high reset
//   tokenValid_i/Ep_i     accepted OUT token and its endpoint number
//   rxDataValid_i/Data_i  payload byte stream
//   rxDataToggle_i        DATA0/DATA1 of the current packet
//   rxPacketDone_i/Ok_i   end of packet and its CRC/PID verdict
//   rxAbort_i             receive error; no handshake is sent
//   resetDataToggle_i     per-endpoint toggle clear
//   epStall_i, epFull_i   per-endpoint halt and FIFO-full status
//   epDataValid_o/Data_o  one-hot FIFO write strobe and shared write data
//   epFillDone_o/Success_o one-hot transaction end and commit qualifier
//   hsValid_o/PacketID_o  handshake request and PID[3:2]
//   busy_o                sequencer is not idle
module usb_out_fill_sequencer #(
  parameter int unsigned EP_CNT = 4
) (
  input  logic              clk12_i,
  input  logic              rst_i,
  input  logic              tokenValid_i,
  input  logic [3:0]        tokenEp_i,
  input  logic              rxDataValid_i,
  input  logic [7:0]        rxData_i,
  input  logic              rxDataToggle_i,
  input  logic              rxPacketDone_i,
  input  logic              rxPacketOk_i,
  input  logic              rxAbort_i,
  input  logic [EP_CNT-1:0] resetDataToggle_i,
  input  logic [EP_CNT-1:0] epStall_i,
  input  logic [EP_CNT-1:0] epFull_i,
  output logic [EP_CNT-1:0] epDataValid_o,
  output logic [7:0]        epData_o,
  output logic [EP_CNT-1:0] epFillDone_o,
  output logic [EP_CNT-1:0] epFillSuccess_o,
  output logic              hsValid_o,
  output logic [1:0]        hsPacketID_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, DONE} stateT;

  // Verdict values are the handshake PID[3:2] codes themselves.
  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NAK   = 2'b10,
    HS_STALL = 2'b11
  } hsPidT;

  stateT             state, stateNext;
  hsPidT             verdict, verdictNext, effVerdict;
  // One-hot endpoint select; all zero for an out-of-range endpoint number.
  logic [EP_CNT-1:0] epSel, epSelNext;
  logic [EP_CNT-1:0] epDataValidNext, epFillDoneNext, epFillSuccessNext;
  logic [7:0]        epDataNext;
  logic              hsValidNext;
  logic [1:0]        hsPacketIDNext;
  logic              commit;
  logic              toggleMatch;

`ifdef USB_OUT_SEQ_TOGGLE_CHECK_EN
  logic [EP_CNT-1:0] toggle;

  assign toggleMatch = (rxDataToggle_i == (|(toggle & epSel)));

  // Commit flips the endpoint's toggle; an explicit reset wins over a same-cycle flip.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      toggle <= '0;
    end else begin
      toggle <= (toggle ^ (commit ? epSel : '0)) & ~resetDataToggle_i;
    end
  end
`else
  logic unusedToggle;

  assign unusedToggle = rxDataToggle_i ^ (^resetDataToggle_i);
  assign toggleMatch  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, verdict and next-output decode.
  always_comb begin
    stateNext         = state;
    epSelNext         = epSel;
    verdictNext       = verdict;
    effVerdict        = verdict;
    epDataValidNext   = '0;
    epDataNext        = 8'h00;
    epFillDoneNext    = '0;
    epFillSuccessNext = '0;
    hsValidNext       = 1'b0;
    hsPacketIDNext    = 2'b00;
    commit            = 1'b0;

    unique case (state)
      IDLE: begin
        if (tokenValid_i) begin
          epSelNext = EP_CNT'(1) << tokenEp_i;
          if ((32'(tokenEp_i) >= EP_CNT) || ((epStall_i & epSelNext) != '0)) begin
            verdictNext = HS_STALL;
            stateNext   = DISCARD;
          end else begin
            verdictNext = HS_ACK;
            stateNext   = RECV;
          end
        end
      end

      RECV, DISCARD: begin
        // A byte arriving with its end-of-packet is handled before the packet ends.
        if ((state == RECV) && rxDataValid_i) begin
          if ((epFull_i & epSel) != '0) begin
            effVerdict = HS_NAK;
            stateNext  = DISCARD;
          end else begin
            epDataValidNext = epSel;
            epDataNext      = rxData_i;
          end
        end
        verdictNext = effVerdict;

        if (rxAbort_i || rxPacketDone_i) begin
          stateNext = DONE;
          // A STALLed transaction never touches a FIFO.
          if (effVerdict != HS_STALL) begin
            epFillDoneNext = epSel;
          end
          if (!rxAbort_i && rxPacketOk_i) begin
            hsValidNext    = 1'b1;
            hsPacketIDNext = effVerdict;
            commit         = (effVerdict == HS_ACK) && toggleMatch;
          end
          if (commit) begin
            epFillSuccessNext = epSel;
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Transaction context and registered outputs.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      epSel           <= '0;
      verdict         <= HS_ACK;
      epDataValid_o   <= '0;
      epData_o        <= 8'h00;
      epFillDone_o    <= '0;
      epFillSuccess_o <= '0;
      hsValid_o       <= 1'b0;
      hsPacketID_o    <= 2'b00;
      busy_o          <= 1'b0;
    end else begin
      epSel           <= epSelNext;
      verdict         <= verdictNext;
      epDataValid_o   <= epDataValidNext;
      epData_o        <= epDataNext;
      epFillDone_o    <= epFillDoneNext;
      epFillSuccess_o <= epFillSuccessNext;
      hsValid_o       <= hsValidNext;
      hsPacketID_o    <= hsPacketIDNext;
      busy_o          <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_usb_out_fill_sequencer.sv
// Self-checking bench for usb_out_fill_sequencer: directed scenarios followed by
// randomized OUT transactions, each checked against a transaction-level model.
module tb_usb_out_fill_sequencer;

  localparam int unsigned EP_CNT = 4;

  logic              clk12_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              tokenValid_i = 1'b0;
  logic [3:0]        tokenEp_i = 4'd0;
  logic              rxDataValid_i = 1'b0;
  logic [7:0]        rxData_i = 8'h00;
  logic              rxDataToggle_i = 1'b0;
  logic              rxPacketDone_i = 1'b0;
  logic              rxPacketOk_i = 1'b0;
  logic              rxAbort_i = 1'b0;
  logic [EP_CNT-1:0] resetDataToggle_i = '0;
  logic [EP_CNT-1:0] epStall_i = '0;
  logic [EP_CNT-1:0] epFull_i = '0;
  logic [EP_CNT-1:0] epDataValid_o;
  logic [7:0]        epData_o;
  logic [EP_CNT-1:0] epFillDone_o;
  logic [EP_CNT-1:0] epFillSuccess_o;
  logic              hsValid_o;
  logic [1:0]        hsPacketID_o;
  logic              busy_o;

  always #5 clk12_i = ~clk12_i;

  usb_out_fill_sequencer #(.EP_CNT(EP_CNT)) dut (
    .clk12_i          (clk12_i),
    .rst_i            (rst_i),
    .tokenValid_i     (tokenValid_i),
    .tokenEp_i        (tokenEp_i),
    .rxDataValid_i    (rxDataValid_i),
    .rxData_i         (rxData_i),
    .rxDataToggle_i   (rxDataToggle_i),
    .rxPacketDone_i   (rxPacketDone_i),
    .rxPacketOk_i     (rxPacketOk_i),
    .rxAbort_i        (rxAbort_i),
    .resetDataToggle_i(resetDataToggle_i),
    .epStall_i        (epStall_i),
    .epFull_i         (epFull_i),
    .epDataValid_o    (epDataValid_o),
    .epData_o         (epData_o),
    .epFillDone_o     (epFillDone_o),
    .epFillSuccess_o  (epFillSuccess_o),
    .hsValid_o        (hsValid_o),
    .hsPacketID_o     (hsPacketID_o),
    .busy_o           (busy_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  byte unsigned      pay[$];
  logic [EP_CNT-1:0] stallMask = '0;
  bit                mtog[EP_CNT];

  logic [EP_CNT-1:0] obsMask[$];
  byte unsigned      obsData[$];
  int                obsStamp[$];
  int                doneCnt, doneStamp, hsCnt, hsStamp;
  logic [EP_CNT-1:0] doneMask, succMask;
  logic [1:0]        hsPid;
  logic              lastBusy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearObs();
    obsMask.delete();
    obsData.delete();
    obsStamp.delete();
    doneCnt   = 0;
    doneStamp = -1;
    hsCnt     = 0;
    hsStamp   = -1;
    doneMask  = '0;
    succMask  = '0;
    hsPid     = 2'b00;
  endtask

  // Sample outputs on the falling edge, then advance one clock.
  task automatic tick();
    @(negedge clk12_i);
    if (epDataValid_o != '0) begin
      obsMask.push_back(epDataValid_o);
      obsData.push_back(epData_o);
      obsStamp.push_back(cyc);
    end
    if (epFillDone_o != '0) begin
      doneCnt++;
      doneMask  = epFillDone_o;
      succMask  = epFillSuccess_o;
      doneStamp = cyc;
    end
    if (hsValid_o) begin
      hsCnt++;
      hsPid   = hsPacketID_o;
      hsStamp = cyc;
    end
    lastBusy = busy_o;
    @(posedge clk12_i);
    cyc++;
    #1;
  endtask

  task automatic resetToggle(input logic [EP_CNT-1:0] m);
    resetDataToggle_i = m;
    tick();
    resetDataToggle_i = '0;
    for (int i = 0; i < EP_CNT; i++) if (m[i]) mtog[i] = 1'b0;
  endtask

  // One OUT transaction carrying the bytes in pay. fullAt: index of the byte seen
  // with the FIFO full (-1 none). abortAt: abort replaces that byte, or ends the
  // packet when equal to its length (-1 none).
  task automatic txn(input int ep, input int fullAt, input int abortAt, input bit ok,
                     input bit tog, input bit sameDone, input bit spurious);
    int                n;
    int                sent;
    int                endCyc;
    int                verdict;
    bit                hsExp;
    bit                commit;
    logic [EP_CNT-1:0] sel;
    byte unsigned      expData[$];

    n   = pay.size();
    sel = EP_CNT'(1) << ep;
    clearObs();
    epStall_i      = stallMask;
    rxDataToggle_i = tog;
    tokenValid_i   = 1'b1;
    tokenEp_i      = 4'(ep);
    tick();
    tokenValid_i = 1'b0;

    sent   = (abortAt >= 0 && abortAt < n) ? abortAt : n;
    endCyc = -1;
    for (int i = 0; i < sent; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      rxDataValid_i = 1'b1;
      rxData_i      = pay[i];
      epFull_i      = (i == fullAt) ? sel : '0;
      if (spurious && i == 0) begin
        tokenValid_i = 1'b1;
        tokenEp_i    = 4'((ep + 1) % 4);
      end
      if (sameDone && abortAt < 0 && i == n - 1) begin
        rxPacketDone_i = 1'b1;
        rxPacketOk_i   = ok;
        endCyc         = cyc;
      end
      tick();
      rxDataValid_i  = 1'b0;
      epFull_i       = '0;
      tokenValid_i   = 1'b0;
      rxPacketDone_i = 1'b0;
      rxPacketOk_i   = 1'b0;
    end
    if (endCyc < 0) begin
      if (abortAt >= 0) begin
        rxAbort_i = 1'b1;
      end else begin
        rxPacketDone_i = 1'b1;
        rxPacketOk_i   = ok;
      end
      endCyc = cyc;
      tick();
      rxAbort_i      = 1'b0;
      rxPacketDone_i = 1'b0;
      rxPacketOk_i   = 1'b0;
    end
    tick();
    tick();

    // Transaction-level expectation.
    if (ep >= EP_CNT || (stallMask & sel) != '0) begin
      verdict = 3;
    end else if (fullAt >= 0 && fullAt < sent) begin
      verdict = 2;
      for (int i = 0; i < fullAt; i++) expData.push_back(pay[i]);
    end else begin
      verdict = 0;
      for (int i = 0; i < sent; i++) expData.push_back(pay[i]);
    end
    hsExp  = (abortAt < 0) && ok;
    commit = hsExp && (verdict == 0);
`ifdef USB_OUT_SEQ_TOGGLE_CHECK_EN
    if (commit) commit = (tog == mtog[ep]);
`endif
    if (commit) mtog[ep] = !mtog[ep];

    chk("strobeCount", 32'(obsMask.size()), 32'(expData.size()));
    foreach (obsMask[i]) begin
      if (i < expData.size()) begin
        chk("strobeSel", 32'(obsMask[i]), 32'(sel));
        chk("strobeData", 32'(obsData[i]), 32'(expData[i]));
        chk("strobeLate", 32'(obsStamp[i] <= endCyc + 1), 32'd1);
      end
    end
    chk("doneCount", 32'(doneCnt), (verdict == 3) ? 32'd0 : 32'd1);
    if (verdict != 3) begin
      chk("doneSel", 32'(doneMask), 32'(sel));
      chk("doneTime", 32'(doneStamp), 32'(endCyc + 1));
    end
    chk("success", 32'(succMask), commit ? 32'(sel) : 32'd0);
    chk("hsCount", 32'(hsCnt), 32'(hsExp));
    if (hsExp) begin
      chk("hsPid", 32'(hsPid), 32'(verdict));
      chk("hsTime", 32'(hsStamp), 32'(endCyc + 1));
    end
    chk("busyAfter", 32'(lastBusy), 32'd0);
  endtask

  task automatic randPay(input int n);
    pay.delete();
    repeat (n) pay.push_back(8'($urandom));
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "DataValid"}, 32'(epDataValid_o), 32'd0);
    chk({tag, "Data"}, 32'(epData_o), 32'd0);
    chk({tag, "FillDone"}, 32'(epFillDone_o), 32'd0);
    chk({tag, "FillSuccess"}, 32'(epFillSuccess_o), 32'd0);
    chk({tag, "HsValid"}, 32'(hsValid_o), 32'd0);
    chk({tag, "HsPid"}, 32'(hsPacketID_o), 32'd0);
    chk({tag, "Busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n, fullAt, abortAt;

    for (int i = 0; i < EP_CNT; i++) mtog[i] = 1'b0;

    // Reset values.
    #12;
    chkOutputsZero("rst");
    @(posedge clk12_i);
    #1 rst_i = 1'b0;
    tick();

    // Three ACKed bytes to ep1.
    pay = '{8'h11, 8'h22, 8'h33};
    txn(1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ep2 goes full on the second byte: NAK.
    randPay(3);
    txn(2, 1, -1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Invalid endpoint, then a halted endpoint: STALL.
    randPay(2);
    txn(5, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    stallMask = 4'b0001;
    randPay(2);
    txn(0, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0);
    stallMask = '0;

    // Bad CRC, then an abort mid-packet, on ep1.
    randPay(3);
    txn(1, -1, -1, 1'b0, mtog[1], 1'b0, 1'b0);
    randPay(4);
    txn(1, -1, 2, 1'b1, mtog[1], 1'b0, 1'b0);

    // Toggle sequence on ep1.
    resetToggle(4'b0010);
    randPay(2);
    txn(1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    randPay(2);
    txn(1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    randPay(2);
    txn(1, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0);
    resetToggle(4'b0010);
    randPay(1);
    txn(1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero-length packet on ep3.
    pay.delete();
    txn(3, -1, -1, 1'b1, mtog[3], 1'b0, 1'b0);

    // Reset in the middle of a transaction.
    clearObs();
    tokenValid_i = 1'b1;
    tokenEp_i    = 4'd1;
    tick();
    tokenValid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rxDataValid_i = 1'b1;
      rxData_i      = 8'(8'hA0 + i);
      tick();
    end
    #2 rst_i = 1'b1;
    #1;
    chkOutputsZero("midRst");
    rxDataValid_i = 1'b0;
    @(posedge clk12_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < EP_CNT; i++) mtog[i] = 1'b0;
    clearObs();
    tick();
    tick();
    chk("midRstNoDone", 32'(doneCnt), 32'd0);
    randPay(3);
    txn(1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 6);
      randPay(n);
      fullAt  = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      abortAt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : -1;
      stallMask = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) resetToggle(4'($urandom));
      txn($urandom_range(0, 5), fullAt, abortAt, ($urandom_range(0, 4) != 0),
          1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
